// File: rtl/instr_sequencer.sv
// ----------------------------------------------------------------------------
// instr_sequencer
//
// Fetch/decode/execute control FSM for the 4-bit processor. It fetches one
// instruction word at a time from program memory, holds it in the instruction
// register (IR), and emits per-instruction PC, ALU and accumulator strobes.
// An opcode of all ones parks the block in HALT until reset.
//
// Fetch handshake: mem_req is the request and mem_ack the response. A word is
// transferred in exactly the cycle where mem_req && mem_ack are both high. The
// IR captures mem_data on that clock edge, and pc_enable pulses in that cycle.
// mem_ack is ignored in any cycle where mem_req is low.
//
// Ports
//   clk         in   rising-edge clock
//   reset_n     in   asynchronous active-low reset
//   run         in   allows new fetches; while low the block waits in FETCH
//   mem_ack     in   mem_data is valid this cycle
//   mem_data    in   instruction word {opcode, operand}
//   zero_flag   in   registered ALU zero flag (used by JZ)
//   carry_flag  in   registered ALU carry flag (used by JC)
//   mem_req     out  fetch request
//   pc_enable   out  PC increment strobe
//   pc_load     out  PC load strobe
//   pc_target   out  PC load value (IR operand)
//   alu_op      out  0 PASS, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR
//   operand     out  IR operand, ALU B input
//   acc_we      out  accumulator write strobe
//   halted      out  high in HALT
//   dbg_state   out  current FSM state (0 FETCH, 1 DECODE, 2 EXECUTE, 3 HALT)
// ----------------------------------------------------------------------------
module instr_sequencer #(
   parameter int WIDTH = 4,
   parameter int OPW   = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 run,
   input  logic                 mem_ack,
   input  logic [OPW+WIDTH-1:0] mem_data,
   input  logic                 zero_flag,
   input  logic                 carry_flag,
   output logic                 mem_req,
   output logic                 pc_enable,
   output logic                 pc_load,
   output logic [WIDTH-1:0]     pc_target,
   output logic [2:0]           alu_op,
   output logic [WIDTH-1:0]     operand,
   output logic                 acc_we,
   output logic                 halted,
   output logic [1:0]           dbg_state
);

   typedef enum logic [1:0] {
      S_FETCH   = 2'd0,
      S_DECODE  = 2'd1,
      S_EXECUTE = 2'd2,
      S_HALT    = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [OPW+WIDTH-1:0] ir_q, ir_d;
   logic [OPW-1:0]       opcode;

   assign opcode    = ir_q[OPW+WIDTH-1:WIDTH];
   assign operand   = ir_q[WIDTH-1:0];
   assign pc_target = ir_q[WIDTH-1:0];
   assign dbg_state = state_q;
   assign halted    = (state_q == S_HALT);

   // The state register already returns to FETCH asynchronously, but FETCH
   // alone would still raise mem_req from run; gating with reset_n keeps the
   // request (and so pc_enable) low for the whole time reset is held.
   assign mem_req   = reset_n && (state_q == S_FETCH) && run;
   assign pc_enable = mem_req && mem_ack;

   // Execute-stage strobes; opcodes A-E fall into the default and act as NOP.
   always_comb begin
      alu_op  = 3'd0;
      acc_we  = 1'b0;
      pc_load = 1'b0;
      if (state_q == S_EXECUTE) begin
         case (opcode)
            OPW'(1): begin alu_op = 3'd0; acc_we = 1'b1; end
            OPW'(2): begin alu_op = 3'd1; acc_we = 1'b1; end
            OPW'(3): begin alu_op = 3'd2; acc_we = 1'b1; end
            OPW'(4): begin alu_op = 3'd3; acc_we = 1'b1; end
            OPW'(5): begin alu_op = 3'd4; acc_we = 1'b1; end
            OPW'(6): begin alu_op = 3'd5; acc_we = 1'b1; end
            OPW'(7): pc_load = 1'b1;
            OPW'(8): pc_load = zero_flag;
            OPW'(9): pc_load = carry_flag;
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      case (state_q)
         S_FETCH: begin
            if (pc_enable) begin
               ir_d    = mem_data;
               state_d = S_DECODE;
            end
         end
         S_DECODE:  state_d = (opcode == {OPW{1'b1}}) ? S_HALT : S_EXECUTE;
         S_EXECUTE: state_d = S_FETCH;
         S_HALT:    state_d = S_HALT;
         default:   state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_FETCH;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
      end
   end

endmodule

// File: tb/tb_instr_sequencer.sv
// ----------------------------------------------------------------------------
// tb_instr_sequencer
//
// Directed bench for instr_sequencer. A reference model tracks the in-flight
// instruction by its age since the fetch ack, and a compare process checks
// every output on every falling edge. A scoreboard queue holds the ALU writes
// and PC loads each program is expected to produce, in order.
// ----------------------------------------------------------------------------
module tb_instr_sequencer;

   logic       clk        = 1'b0;
   logic       reset_n    = 1'b1;
   logic       run        = 1'b0;
   logic       mem_ack    = 1'b0;
   logic [7:0] mem_data   = 8'h00;
   logic       zero_flag  = 1'b0;
   logic       carry_flag = 1'b0;

   logic       mem_req, pc_enable, pc_load, acc_we, halted;
   logic [3:0] pc_target, operand;
   logic [2:0] alu_op;
   logic [1:0] dbg_state;

   int n_checks = 0;
   int n_pass   = 0;

   // {is_pc_load, alu_op, operand_or_target}
   logic [8:0] exp_q[$];

   // Reference model: age of the in-flight instruction since its ack.
   bit         m_halted = 1'b0;
   int         m_age    = 0;   // 0 waiting for fetch, 1 one cycle after ack, 2 two cycles
   logic [7:0] m_ir     = 8'h00;

   instr_sequencer #(.WIDTH(4), .OPW(4)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .run        (run),
      .mem_ack    (mem_ack),
      .mem_data   (mem_data),
      .zero_flag  (zero_flag),
      .carry_flag (carry_flag),
      .mem_req    (mem_req),
      .pc_enable  (pc_enable),
      .pc_load    (pc_load),
      .pc_target  (pc_target),
      .alu_op     (alu_op),
      .operand    (operand),
      .acc_we     (acc_we),
      .halted     (halted),
      .dbg_state  (dbg_state)
   );

   // ---------------- clock ----------------
   always #10 clk = ~clk;

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic logic [17:0] dut_out();
      return {dbg_state, mem_req, pc_enable, pc_load, pc_target, alu_op, operand, acc_we, halted};
   endfunction

   function automatic logic [17:0] model_out();
      logic [3:0] op;
      logic       mreq, pce, pcl, we;
      logic [2:0] aop;
      logic [1:0] st;
      op  = m_ir[7:4];
      aop = 3'd0;
      we  = 1'b0;
      pcl = 1'b0;
      if (!reset_n) return 18'd0;
      mreq = run && !m_halted && (m_age == 0);
      pce  = mreq && mem_ack;
      if (!m_halted && m_age == 2) begin
         if (op >= 4'd1 && op <= 4'd6) begin
            we  = 1'b1;
            aop = (op == 4'd1) ? 3'd0 : 3'(op - 4'd1);
         end
         pcl = (op == 4'd7) || (op == 4'd8 && zero_flag) || (op == 4'd9 && carry_flag);
      end
      st = m_halted ? 2'd3 : 2'(m_age);
      return {st, mreq, pce, pcl, m_ir[3:0], aop, m_ir[3:0], we, m_halted};
   endfunction

   // Model advance: an instruction is taken on a request+ack cycle, then
   // spends one cycle being decoded and one executing; opcode F halts for good.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_halted = 1'b0;
         m_age    = 0;
         m_ir     = 8'h00;
      end else if (!m_halted) begin
         if (m_age == 0) begin
            if (run && mem_ack) begin
               m_ir  = mem_data;
               m_age = 1;
            end
         end else if (m_age == 1) begin
            if (m_ir[7:4] == 4'hF) begin
               m_halted = 1'b1;
               m_age    = 0;
            end else begin
               m_age = 2;
            end
         end else begin
            m_age = 0;
         end
      end
   end

   // Compare process and scoreboard.
   always @(negedge clk) begin
      check("cycle_outputs", 32'(dut_out()), 32'(model_out()));
      if (reset_n && acc_we) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL sb_acc: got write op=%0d operand=0x%0h, expected none", alu_op, operand);
         end else begin
            check("sb_acc", {23'd0, 1'b0, alu_op, operand}, {23'd0, exp_q.pop_front()});
         end
      end
      if (reset_n && pc_load) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL sb_jump: got load target=0x%0h, expected none", pc_target);
         end else begin
            check("sb_jump", {23'd0, 1'b1, 3'd0, pc_target}, {23'd0, exp_q.pop_front()});
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Inputs change 1 time unit after the rising edge; literal checks happen 2
   // units later, well before the falling-edge compare.
   task automatic drive(input logic r, input logic a, input logic [7:0] d);
      run      = r;
      mem_ack  = a;
      mem_data = d;
      #2;
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset_n    = 1'b0;
      run        = 1'b0;
      mem_ack    = 1'b0;
      mem_data   = 8'h00;
      zero_flag  = 1'b0;
      carry_flag = 1'b0;
      next();
      next();
      reset_n = 1'b1;
   endtask

   // Zero-wait fetch of one instruction; returns inside its third cycle
   // (EXECUTE, or HALT for opcode F) so the caller can check that cycle.
   task automatic exec_instr(input logic [7:0] instr);
      drive(1'b1, 1'b1, instr);
      check("ack_pc_enable", pc_enable, 1);
      next();
      drive(1'b1, 1'b0, 8'hEE);
      check("decode_quiet", {mem_req, pc_enable, pc_load, acc_we, halted}, 0);
      next();
      drive(1'b1, 1'b0, 8'hEE);
   endtask

   // ---------------- stimulus tables ----------------
   logic [7:0] alu_instr [5] = '{8'h51, 8'h6C, 8'h37, 8'hA5, 8'h0C};
   logic       alu_we    [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
   logic [2:0] alu_opx   [5] = '{3'd4, 3'd5, 3'd2, 3'd0, 3'd0};

   initial begin
      // Reset held with run and ack high: everything quiet.
      #1;
      reset_n  = 1'b0;
      run      = 1'b1;
      mem_ack  = 1'b1;
      mem_data = 8'hF5;
      repeat (3) begin
         @(posedge clk);
         #3;
         check("reset_quiet", 32'(dut_out()), 0);
      end

      // Release, fetch LDI 5 in the very first cycle, then ADD 3.
      reset_n = 1'b1;
      drive(1'b1, 1'b1, 8'h15);
      check("first_req", mem_req, 1);
      check("ldi_pc_enable", pc_enable, 1);
      exp_q.push_back({1'b0, 3'd0, 4'h5});
      next();
      drive(1'b1, 1'b0, 8'hEE);
      check("ldi_decode", {mem_req, pc_enable, acc_we}, 0);
      next();
      drive(1'b1, 1'b0, 8'hEE);
      check("ldi_exec", {acc_we, alu_op, operand}, {1'b1, 3'd0, 4'h5});
      next();
      exp_q.push_back({1'b0, 3'd1, 4'h3});
      exec_instr(8'h23);
      check("add_exec", {acc_we, alu_op, operand}, {1'b1, 3'd1, 4'h3});
      next();
      check("sb_drain_ldi_add", exp_q.size(), 0);

      // Jumps.
      apply_reset();
      exp_q.push_back({1'b1, 3'd0, 4'hA});
      exec_instr(8'h7A);
      check("jmp_exec", {pc_load, pc_enable, pc_target}, {1'b1, 1'b0, 4'hA});
      next();

      zero_flag = 1'b0; carry_flag = 1'b1;
      exec_instr(8'h83);
      check("jz_not_taken", pc_load, 0);
      next();

      zero_flag = 1'b1; carry_flag = 1'b0;
      exp_q.push_back({1'b1, 3'd0, 4'h3});
      exec_instr(8'h83);
      check("jz_taken", {pc_load, pc_target}, {1'b1, 4'h3});
      next();

      zero_flag = 1'b0; carry_flag = 1'b1;
      exp_q.push_back({1'b1, 3'd0, 4'hF});
      exec_instr(8'h9F);
      check("jc_taken", {pc_load, pc_target}, {1'b1, 4'hF});
      next();

      zero_flag = 1'b1; carry_flag = 1'b0;
      exec_instr(8'h9F);
      check("jc_not_taken", pc_load, 0);
      next();
      zero_flag = 1'b0;
      check("sb_drain_jumps", exp_q.size(), 0);

      // Wait states: ack on the 4th request cycle.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 8'h46);
         check("wait_req", {mem_req, pc_enable}, 2'b10);
         next();
      end
      exp_q.push_back({1'b0, 3'd3, 4'h6});
      exec_instr(8'h46);
      check("and_exec", {acc_we, alu_op, operand}, {1'b1, 3'd3, 4'h6});
      next();

      // run drops while waiting; a late ack must be ignored.
      drive(1'b1, 1'b0, 8'h00);
      check("run_req_high", mem_req, 1);
      next();
      drive(1'b0, 1'b0, 8'h00);
      check("run_low_req", mem_req, 0);
      next();
      drive(1'b0, 1'b1, 8'h7C);
      check("late_ack_ignored", {mem_req, pc_enable}, 0);
      next();
      drive(1'b0, 1'b0, 8'h00);
      check("still_fetch", {dbg_state, operand}, {2'd0, 4'h6});
      next();

      // Remaining ALU ops and NOP-class opcodes.
      for (int i = 0; i < 5; i++) begin
         if (alu_we[i]) exp_q.push_back({1'b0, alu_opx[i], alu_instr[i][3:0]});
         exec_instr(alu_instr[i]);
         check("alu_exec", {acc_we, alu_op}, {alu_we[i], alu_opx[i]});
         next();
      end
      check("sb_drain_alu", exp_q.size(), 0);

      // Halt is absorbing until reset.
      exec_instr(8'hF0);
      check("halted_two_after_ack", {halted, mem_req}, 2'b10);
      for (int i = 0; i < 20; i++) begin
         next();
         drive(1'b1, 1'b1, 8'h15);
         check("halt_no_req", {halted, mem_req, pc_enable}, 3'b100);
      end
      next();
      reset_n = 1'b0;
      #1;
      check("halt_reset_async", halted, 0);
      next();
      reset_n = 1'b1;
      exp_q.push_back({1'b0, 3'd0, 4'h5});
      exec_instr(8'h15);
      check("resume_exec", {acc_we, operand}, {1'b1, 4'h5});
      next();

      // Reset in the middle of an ADD execute cycle.
      exec_instr(8'h29);
      check("add_we_pre", {acc_we, alu_op}, {1'b1, 3'd1});
      #2;
      reset_n = 1'b0;
      #1;
      check("add_we_async_drop", {acc_we, alu_op, operand, pc_load}, 0);
      next();
      next();
      reset_n = 1'b1;
      #2;
      check("post_reset_fetch", {dbg_state, operand, mem_req}, {2'd0, 4'h0, 1'b1});
      next();

      check("sb_drain_final", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
